mmk_deadlock_report_unit: RTL and testbench

// Consumer stage of the per-process deadlock detect units in the MatrixMultiplicationKernel.

---
 rtl/mmk_deadlock_pkg.sv | 35 +++
 rtl/mmk_dl_path_buf.sv | 74 +++++++
 rtl/mmk_deadlock_report_unit.sv | 164 ++++++++++++++++
 tb/tb_mmk_deadlock_report_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mmk_deadlock_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mmk_deadlock_pkg
// Brief   : Shared types and helpers for the MatrixMultiplicationKernel
//           deadlock detect/report stages.
// Revision: 1.0
// ============================================================================
package mmk_deadlock_pkg;

   localparam int c_MAX_PROC = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      TRACE  = 3'd2,
      REPORT = 3'd3,
      DONE   = 3'd4
   } dl_state_t;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [7:0] lowest_set_idx(input logic [c_MAX_PROC-1:0] v);
      logic [7:0] r;
      r = '0;
      for (int i = c_MAX_PROC - 1; i >= 0; i--) begin
         if (v[i]) r = 8'(i);
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mmk_dl_path_buf.sv
`default_nettype none
// ============================================================================
// Module  : mmk_dl_path_buf
// Brief   : Register buffer holding the traced process path, read in order.
// Revision: 1.0
// ============================================================================
module mmk_dl_path_buf #(
   parameter  int DEPTH = 8,
   parameter  int W     = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          init,
   input  logic [W-1:0]  init_data,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   input  logic          clear,
   output logic [W-1:0]  rd_data,
   output logic          rd_last,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          overflow
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   assign full     = (r_count == CW'(DEPTH));
   assign rd_data  = r_mem[r_rd_ptr];
   assign rd_last  = ({1'b0, r_rd_ptr} == (r_count - CW'(1)));
   assign count    = r_count;
   assign overflow = r_overflow;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (init) begin
         r_mem[0]   <= init_data;
         r_wr_ptr   <= PW'(1);
         r_rd_ptr   <= '0;
         r_count    <= CW'(1);
         r_overflow <= 1'b0;
      end else begin
         // A push into a full buffer is dropped and only flagged.
         if (push) begin
            if (full) begin
               r_overflow <= 1'b1;
            end else begin
               r_mem[r_wr_ptr] <= push_data;
               r_wr_ptr        <= r_wr_ptr + PW'(1);
               r_count         <= r_count + CW'(1);
            end
         end
         if (pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/mmk_deadlock_report_unit.sv
`default_nettype none
// ============================================================================
// Module  : mmk_deadlock_report_unit
// Brief   : Elects a deadlock origin, traces the token around the dependence
//           cycle and streams the visited process IDs out as a report.
// Revision: 1.0
// ============================================================================
module mmk_deadlock_report_unit
   import mmk_deadlock_pkg::*;
#(
   parameter  int PROC_NUM      = 4,
   parameter  int PATH_DEPTH    = 8,
   parameter  int TRACE_TIMEOUT = 1024,
   localparam int IDX_W         = idx_w(PROC_NUM)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PROC_NUM-1:0] dl_detect_vec,
   input  logic [PROC_NUM-1:0] token_seen_vec,
   output logic                dl_detect_in,
   output logic [PROC_NUM-1:0] origin_vec,
   output logic                token_clear,
   output logic                rpt_valid,
   input  logic                rpt_ready,
   output logic [IDX_W-1:0]    rpt_data,
   output logic                rpt_last,
   output logic                rpt_timeout,
   output logic                busy,
   input  logic                sw_clear
);

   localparam int c_TW = $clog2(TRACE_TIMEOUT) + 1;
   localparam int c_CW = $clog2(PATH_DEPTH) + 1;

   dl_state_t         r_state, w_next;
   logic [IDX_W-1:0]  r_origin_idx, r_last_idx;
   logic [c_TW-1:0]   r_timer;
   logic              r_dl_detect_in, r_timeout;

   logic [PROC_NUM-1:0] w_origin_oh, w_others;
   logic [IDX_W-1:0]    w_cand, w_detect_idx, w_buf_data;
   logic [c_CW-1:0]     w_buf_count, w_count_eff;
   logic                w_append, w_grow, w_drop, w_home, w_expire;
   logic                w_buf_last, w_buf_full, w_buf_ovf;
   logic                w_load_origin, w_buf_init, w_buf_pop, w_buf_clear;
   logic                w_set_dl, w_set_to, w_clear_flags, w_timer_clr, w_timer_inc;

   assign w_origin_oh  = PROC_NUM'(1) << r_origin_idx;
   assign w_others     = token_seen_vec & ~w_origin_oh;
   assign w_cand       = IDX_W'(lowest_set_idx(c_MAX_PROC'(w_others)));
   assign w_detect_idx = IDX_W'(lowest_set_idx(c_MAX_PROC'(dl_detect_vec)));

   // Append is evaluated before the home test, so home sees the updated count.
   assign w_append    = (|w_others) && (w_cand != r_last_idx);
   assign w_grow      = w_append && !w_buf_full;
   assign w_drop      = w_append && w_buf_full;
   assign w_count_eff = w_buf_count + c_CW'(w_grow);
   assign w_home      = token_seen_vec[r_origin_idx] && dl_detect_vec[r_origin_idx]
                        && (w_count_eff >= c_CW'(2));
   assign w_expire    = (r_timer == c_TW'(TRACE_TIMEOUT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      origin_vec    = '0;
      token_clear   = 1'b0;
      w_load_origin = 1'b0;
      w_buf_init    = 1'b0;
      w_buf_pop     = 1'b0;
      w_buf_clear   = 1'b0;
      w_set_dl      = 1'b0;
      w_set_to      = 1'b0;
      w_clear_flags = 1'b0;
      w_timer_clr   = 1'b0;
      w_timer_inc   = 1'b0;
      case (r_state)
         IDLE: begin
            if (|dl_detect_vec) begin
               w_load_origin = 1'b1;
               w_next        = ARM;
            end
         end
         ARM: begin
            origin_vec  = w_origin_oh;
            w_set_dl    = 1'b1;
            w_buf_init  = 1'b1;
            w_timer_clr = 1'b1;
            w_next      = TRACE;
         end
         TRACE: begin
            w_timer_inc = 1'b1;
            token_clear = w_home || w_expire;
            w_set_to    = w_drop || w_expire;
            if (w_drop || w_home || w_expire) w_next = REPORT;
         end
         REPORT: begin
            if (rpt_ready) begin
               if (w_buf_last) w_next    = DONE;
               else            w_buf_pop = 1'b1;
            end
         end
         DONE: begin
            if (sw_clear) begin
               w_buf_clear   = 1'b1;
               w_clear_flags = 1'b1;
               w_next        = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_origin_idx   <= '0;
         r_last_idx     <= '0;
         r_timer        <= '0;
         r_dl_detect_in <= 1'b0;
         r_timeout      <= 1'b0;
      end else begin
         if (w_load_origin) r_origin_idx <= w_detect_idx;
         if (w_buf_init)                r_last_idx <= r_origin_idx;
         else if (w_timer_inc && w_grow) r_last_idx <= w_cand;
         if (w_set_dl)           r_dl_detect_in <= 1'b1;
         else if (w_clear_flags) r_dl_detect_in <= 1'b0;
         if (w_set_to)           r_timeout <= 1'b1;
         else if (w_clear_flags) r_timeout <= 1'b0;
         if (w_timer_clr) r_timer <= '0;
         else if (w_timer_inc && (r_timer != {c_TW{1'b1}})) r_timer <= r_timer + c_TW'(1);
      end
   end

   mmk_dl_path_buf #(
      .DEPTH (PATH_DEPTH),
      .W     (IDX_W)
   ) u_path_buf (
      .clock     (clock),
      .reset     (reset),
      .init      (w_buf_init),
      .init_data (r_origin_idx),
      .push      (w_timer_inc && w_append),
      .push_data (w_cand),
      .pop       (w_buf_pop),
      .clear     (w_buf_clear),
      .rd_data   (w_buf_data),
      .rd_last   (w_buf_last),
      .count     (w_buf_count),
      .full      (w_buf_full),
      .overflow  (w_buf_ovf)
   );

   assign dl_detect_in = r_dl_detect_in;
   assign rpt_valid    = (r_state == REPORT);
   assign rpt_data     = rpt_valid ? w_buf_data : '0;
   assign rpt_last     = rpt_valid && w_buf_last;
   assign rpt_timeout  = r_timeout || w_buf_ovf;
   assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mmk_deadlock_report_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmk_deadlock_report_unit
// Brief   : Directed, table-driven self-checking bench for the report unit.
// Revision: 1.0
// ============================================================================
module tb_mmk_deadlock_report_unit;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] dl_detect_vec = '0;
   logic [3:0] token_seen_vec = '0;
   logic       rpt_ready = 1'b0;
   logic       sw_clear = 1'b0;
   logic       dl_detect_in, token_clear, rpt_valid, rpt_last, rpt_timeout, busy;
   logic [3:0] origin_vec;
   logic [1:0] rpt_data;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mmk_deadlock_report_unit #(
      .PROC_NUM      (4),
      .PATH_DEPTH    (8),
      .TRACE_TIMEOUT (16)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .dl_detect_vec  (dl_detect_vec),
      .token_seen_vec (token_seen_vec),
      .dl_detect_in   (dl_detect_in),
      .origin_vec     (origin_vec),
      .token_clear    (token_clear),
      .rpt_valid      (rpt_valid),
      .rpt_ready      (rpt_ready),
      .rpt_data       (rpt_data),
      .rpt_last       (rpt_last),
      .rpt_timeout    (rpt_timeout),
      .busy           (busy),
      .sw_clear       (sw_clear)
   );

   // Observed outputs: {dl_in, origin[3:0], tclr, valid, data[1:0], last, tmo, busy}
   wire [11:0] w_obs = {dl_detect_in, origin_vec, token_clear, rpt_valid,
                        rpt_data, rpt_last, rpt_timeout, busy};

   function automatic logic [11:0] e(input logic dl_in, input logic [3:0] ov,
                                     input logic tc, input logic v, input logic [1:0] d,
                                     input logic l, input logic to, input logic b);
      return {dl_in, ov, tc, v, d, l, to, b};
   endfunction

   typedef struct {
      logic [3:0]  dl;
      logic [3:0]  ts;
      logic        rdy;
      logic        clr;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl [14];

   // Called at posedge+1: drive, check at negedge, advance to next posedge+1.
   task automatic cyc(input logic [3:0] dl, input logic [3:0] ts, input logic rdy,
                      input logic clr, input logic [11:0] exp, input string nm);
      dl_detect_vec  = dl;
      token_seen_vec = ts;
      rpt_ready      = rdy;
      sw_clear       = clr;
      @(negedge clock);
      checks++;
      if (w_obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (dl_in,origin,tclr,valid,data,last,tmo,busy)",
                  nm, w_obs, exp);
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Origin 2, cycle 2->0->3->2 with a duplicate sighting of 0.
      tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0)};
      tbl[1]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0)};
      tbl[2]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, e(0, 4'b0100, 0, 0, 2'd0, 0, 0, 1)};
      tbl[3]  = '{4'b0100, 4'b0001, 1'b0, 1'b0, e(1, 4'b0000, 0, 0, 2'd0, 0, 0, 1)};
      tbl[4]  = '{4'b0100, 4'b0001, 1'b0, 1'b0, e(1, 4'b0000, 0, 0, 2'd0, 0, 0, 1)};
      tbl[5]  = '{4'b0100, 4'b1000, 1'b0, 1'b0, e(1, 4'b0000, 0, 0, 2'd0, 0, 0, 1)};
      tbl[6]  = '{4'b0100, 4'b0100, 1'b0, 1'b0, e(1, 4'b0000, 1, 0, 2'd0, 0, 0, 1)};
      tbl[7]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, e(1, 4'b0000, 0, 1, 2'd2, 0, 0, 1)};
      tbl[8]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, e(1, 4'b0000, 0, 1, 2'd0, 0, 0, 1)};
      tbl[9]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, e(1, 4'b0000, 0, 1, 2'd3, 1, 0, 1)};
      tbl[10] = '{4'b0100, 4'b0000, 1'b1, 1'b0, e(1, 4'b0000, 0, 1, 2'd3, 1, 0, 1)};
      tbl[11] = '{4'b0001, 4'b0000, 1'b0, 1'b0, e(1, 4'b0000, 0, 0, 2'd0, 0, 0, 1)};
      tbl[12] = '{4'b0000, 4'b0000, 1'b0, 1'b1, e(1, 4'b0000, 0, 0, 2'd0, 0, 0, 1)};
      tbl[13] = '{4'b0000, 4'b0000, 1'b0, 1'b0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0)};

      repeat (2) @(posedge clock);
      #1 reset = 1'b1;

      for (int i = 0; i < 14; i++)
         cyc(tbl[i].dl, tbl[i].ts, tbl[i].rdy, tbl[i].clr, tbl[i].exp, $sformatf("cyc_%0d", i));

      // Simultaneous detect 1010 -> origin 1; report stalled for 5 cycles.
      cyc(4'b1010, 4'b0000, 0, 0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0), "sim_idle");
      cyc(4'b1010, 4'b0000, 0, 0, e(0, 4'b0010, 0, 0, 2'd0, 0, 0, 1), "sim_arm");
      cyc(4'b1010, 4'b0100, 0, 0, e(1, 4'b0000, 0, 0, 2'd0, 0, 0, 1), "sim_tr0");
      cyc(4'b0010, 4'b0010, 0, 0, e(1, 4'b0000, 1, 0, 2'd0, 0, 0, 1), "sim_home");
      for (int i = 0; i < 5; i++)
         cyc(4'b0000, 4'b0000, 0, 0, e(1, 4'b0000, 0, 1, 2'd1, 0, 0, 1), $sformatf("stall_%0d", i));
      cyc(4'b0000, 4'b0000, 1, 0, e(1, 4'b0000, 0, 1, 2'd1, 0, 0, 1), "sim_rpt0");
      cyc(4'b0000, 4'b0000, 1, 0, e(1, 4'b0000, 0, 1, 2'd2, 1, 0, 1), "sim_rpt1");
      cyc(4'b0000, 4'b0000, 0, 1, e(1, 4'b0000, 0, 0, 2'd0, 0, 0, 1), "sim_done");
      cyc(4'b0000, 4'b0000, 0, 0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0), "sim_idle2");

      // No token return: timeout after 16 TRACE cycles.
      cyc(4'b0001, 4'b0000, 0, 0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0), "to_idle");
      cyc(4'b0001, 4'b0000, 0, 0, e(0, 4'b0001, 0, 0, 2'd0, 0, 0, 1), "to_arm");
      for (int i = 0; i < 16; i++)
         cyc(4'b0001, 4'b0000, 0, 0, e(1, 4'b0000, logic'(i == 15), 0, 2'd0, 0, 0, 1),
             $sformatf("to_tr%0d", i));
      cyc(4'b0000, 4'b0000, 1, 0, e(1, 4'b0000, 0, 1, 2'd0, 1, 1, 1), "to_rpt");
      cyc(4'b0000, 4'b0000, 0, 1, e(1, 4'b0000, 0, 0, 2'd0, 0, 1, 1), "to_done");
      cyc(4'b0000, 4'b0000, 0, 0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0), "to_idle2");

      // Path overflow: origin 0 plus 7 appends fill the buffer, 8th is dropped.
      begin
         logic [3:0] ts_seq [8];
         logic [1:0] path [8];
         ts_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100};
         path   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
         cyc(4'b0001, 4'b0000, 0, 0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0), "ov_idle");
         cyc(4'b0001, 4'b0000, 0, 0, e(0, 4'b0001, 0, 0, 2'd0, 0, 0, 1), "ov_arm");
         for (int i = 0; i < 8; i++)
            cyc(4'b0001, ts_seq[i], 0, 0, e(1, 4'b0000, 0, 0, 2'd0, 0, 0, 1), $sformatf("ov_tr%0d", i));
         for (int i = 0; i < 8; i++)
            cyc(4'b0000, 4'b0000, 1, 0, e(1, 4'b0000, 0, 1, path[i], logic'(i == 7), 1, 1),
                $sformatf("ov_rpt%0d", i));
         cyc(4'b0000, 4'b0000, 0, 1, e(1, 4'b0000, 0, 0, 2'd0, 0, 1, 1), "ov_done");
         cyc(4'b0000, 4'b0000, 0, 0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0), "ov_idle2");
      end

      // Asynchronous reset in the middle of TRACE, then a clean restart.
      cyc(4'b0100, 4'b0000, 0, 0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0), "rs_idle");
      cyc(4'b0100, 4'b0000, 0, 0, e(0, 4'b0100, 0, 0, 2'd0, 0, 0, 1), "rs_arm");
      cyc(4'b0100, 4'b0001, 0, 0, e(1, 4'b0000, 0, 0, 2'd0, 0, 0, 1), "rs_tr0");
      dl_detect_vec  = 4'b0000;
      token_seen_vec = 4'b0000;
      reset = 1'b0;
      #1;
      checks++;
      if (w_obs !== 12'h000) begin
         errors++;
         $display("FAIL rs_async: got %h expected %h", w_obs, 12'h000);
      end
      #2 reset = 1'b1;
      @(posedge clock);
      #1;
      cyc(4'b0000, 4'b0000, 0, 0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0), "rs_after");
      cyc(4'b0010, 4'b0000, 0, 0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0), "rs2_idle");
      cyc(4'b0010, 4'b0000, 0, 0, e(0, 4'b0010, 0, 0, 2'd0, 0, 0, 1), "rs2_arm");
      cyc(4'b0010, 4'b0001, 0, 0, e(1, 4'b0000, 0, 0, 2'd0, 0, 0, 1), "rs2_tr0");
      cyc(4'b0010, 4'b0010, 0, 0, e(1, 4'b0000, 1, 0, 2'd0, 0, 0, 1), "rs2_home");
      cyc(4'b0000, 4'b0000, 1, 0, e(1, 4'b0000, 0, 1, 2'd1, 0, 0, 1), "rs2_rpt0");
      cyc(4'b0000, 4'b0000, 1, 0, e(1, 4'b0000, 0, 1, 2'd0, 1, 0, 1), "rs2_rpt1");
      cyc(4'b0000, 4'b0000, 0, 1, e(1, 4'b0000, 0, 0, 2'd0, 0, 0, 1), "rs2_done");
      cyc(4'b0000, 4'b0000, 0, 0, e(0, 4'b0000, 0, 0, 2'd0, 0, 0, 0), "rs2_idle2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
